// File: rtl/ghostbus_host.sv
// ghostbus_host: ghostbus initiator. Turns a valid/ready command stream into
// single ghostbus write/read transactions (one outstanding at a time) and
// returns read data on a valid/ready response stream. The responder has no
// acknowledge, so read data is sampled a fixed RD cycles after the read strobe.
//
// Ports:
//   gb_clk, rst_n                  clock (also feeds the responder), async active-low reset
//   cmd_valid/cmd_ready            command handshake
//   cmd_we, cmd_addr, cmd_wdata    command: 1 = write, address, write data
//   rsp_valid/rsp_ready, rsp_rdata read response handshake and captured data
//   gb_addr, gb_wdata              bus address / write data (held between transactions)
//   gb_wen, gb_wstb, gb_rstb       write enable, write strobe (= wen), read strobe
//   gb_rdata                       bus read data from the responder
//   wr_count, rd_count             completed write / read counters, wrapping
module ghostbus_host #(
    parameter int AW = 24,
    parameter int DW = 32,
    parameter int RD = 1,
    parameter int CW = 16
) (
    input  logic          gb_clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic [AW-1:0] gb_addr,
    output logic [DW-1:0] gb_wdata,
    output logic          gb_wen,
    output logic          gb_wstb,
    output logic          gb_rstb,
    input  logic [DW-1:0] gb_rdata,
    output logic [CW-1:0] wr_count,
    output logic [CW-1:0] rd_count
);

    if (RD < 1 || RD > 15) begin : g_bad_rd
        $error("ghostbus_host: RD=%0d is outside the legal range 1..15", RD);
    end

    typedef enum logic [2:0] {
        S_RESET, S_IDLE, S_WRITE, S_READ, S_WAIT, S_RESP
    } state_t;

    state_t     state, state_nx;
    logic [3:0] wait_cnt;
    logic       accept;
    logic       last_wait;

    assign accept    = (state == S_IDLE) && cmd_valid;
    // Final WAIT cycle: gb_rdata is valid now and is captured at this edge.
    assign last_wait = (state == S_WAIT) && (wait_cnt == 4'd0);

    always_ff @(posedge gb_clk or negedge rst_n) begin
        if (!rst_n) state <= S_RESET;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_RESET: state_nx = S_IDLE;
            S_IDLE:  if (cmd_valid) state_nx = cmd_we ? S_WRITE : S_READ;
            S_WRITE: state_nx = S_IDLE;
            S_READ:  state_nx = S_WAIT;
            S_WAIT:  if (wait_cnt == 4'd0) state_nx = S_RESP;
            S_RESP:  if (rsp_ready) state_nx = S_IDLE;
            default: state_nx = S_RESET;
        endcase
    end

    // Every output is a flop. Strobes and handshake flags are decoded from the
    // next state so they line up with the state they describe.
    always_ff @(posedge gb_clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            gb_addr   <= '0;
            gb_wdata  <= '0;
            gb_wen    <= 1'b0;
            gb_wstb   <= 1'b0;
            gb_rstb   <= 1'b0;
            wr_count  <= '0;
            rd_count  <= '0;
            wait_cnt  <= '0;
        end else begin
            cmd_ready <= (state_nx == S_IDLE);
            gb_wen    <= (state_nx == S_WRITE);
            gb_wstb   <= (state_nx == S_WRITE);
            gb_rstb   <= (state_nx == S_READ);
            rsp_valid <= (state_nx == S_RESP);

            // Address stays put until the next accepted command so the
            // responder's combinational decode is stable through RESP.
            if (accept) begin
                gb_addr <= cmd_addr;
                if (cmd_we) gb_wdata <= cmd_wdata;
            end

            // WAIT spans RD cycles: load RD-1 while in READ, stop at zero.
            if (state == S_READ)      wait_cnt <= 4'(RD - 1);
            else if (state == S_WAIT) wait_cnt <= wait_cnt - 4'd1;

            if (last_wait) rsp_rdata <= gb_rdata;

            if (state == S_WRITE)             wr_count <= wr_count + CW'(1);
            if (state == S_RESP && rsp_ready) rd_count <= rd_count + CW'(1);
        end
    end

endmodule

// File: doc/ghostbus_host.md
Name: ghostbus_host

Overview:
- Bus initiator that drives the ghostbus from a valid/ready command stream and returns read data on a valid/ready response stream.
- Sits upstream of a ghostbus-decoded top: its gb_* outputs connect directly to the responder's clk/addr/wdata/wen/wstb/rstb/rdata ports.
- One transaction outstanding at a time.
- The responder gives no acknowledge, so read data is sampled after a fixed, parameterised read latency.

Parameters:
- AW, 24: ghostbus address width.
- DW, 32: ghostbus data width.
- RD, 1: cycles from the rstb cycle to valid gb_rdata. Legal range 1..15.
- CW, 16: width of the transaction counters.

Ports:
- gb_clk  input  1  sole clock; also feeds the responder's clk port.
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  host can accept a command.
- cmd_we  input  1  1 = write, 0 = read.
- cmd_addr  input  AW  target address.
- cmd_wdata  input  DW  write data; ignored for reads.
- rsp_valid  output  1  read response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rdata  output  DW  captured read data.
- gb_addr  output  AW  bus address.
- gb_wdata  output  DW  bus write data.
- gb_wen  output  1  write enable.
- gb_wstb  output  1  write strobe; identical to gb_wen.
- gb_rstb  output  1  read strobe.
- gb_rdata  input  DW  bus read data.
- wr_count  output  CW  completed writes, wraps modulo 2^CW.
- rd_count  output  CW  completed reads, wraps modulo 2^CW.

Behaviour:
- All outputs are registered.
- While rst_n=0, every output is 0 and the state is RESET. This takes effect immediately (asynchronous) at any point, including mid-transaction; any pending read is discarded with no response.
- State machine: RESET, IDLE, WRITE, READ, WAIT, RESP.
  - RESET -> IDLE on the first gb_clk edge after rst_n rises. cmd_ready goes to 1 in that same transition.
  - cmd_ready=1 only in IDLE. A command is accepted in any IDLE cycle with cmd_valid=1; call that cycle T.
  - On acceptance, cmd_ready drops to 0 in T+1, and gb_addr and gb_wdata are loaded in T+1.
  - cmd_we=1 -> WRITE: in T+1 only, gb_wen=gb_wstb=1.
    - T+2: wen and wstb return to 0, wr_count increments, state is IDLE with cmd_ready=1.
    - Maximum write throughput is one write per 2 cycles.
  - cmd_we=0 -> READ: in T+1 only, gb_rstb=1 and gb_wen=0.
    - WAIT then counts RD cycles. gb_rdata is sampled at the end of cycle T+1+RD and loaded into rsp_rdata.
    - rsp_valid=1 from cycle T+2+RD (state RESP).
  - RESP: rsp_rdata and rsp_valid hold until the cycle where rsp_ready=1. The next cycle has rsp_valid=0, rd_count incremented, state IDLE, cmd_ready=1.
  - rsp_ready asserted early (before RESP) has no effect. Response latency with rsp_ready held at 1 is RD+2 cycles after T.
- Bus output rules:
  - gb_addr is held constant from T+1 through the sample cycle and through RESP. Responders decode the address combinationally.
  - In IDLE, gb_addr and gb_wdata keep their last values; gb_wen, gb_wstb and gb_rstb are 0.
  - gb_wen and gb_rstb are never both 1.
  - gb_wdata is not updated by reads.
- cmd_valid is ignored outside IDLE; commands are neither buffered nor dropped silently, because cmd_ready=0 there.
- Counters wrap from 2^CW-1 to 0 with no flag.
- RD outside 1..15 is a configuration error and is caught by an elaboration-time check.

Test Plan:
- Write, RD=1: reset, then cmd write addr=0x000001 data=0x0000000E -> in T+1 gb_addr=0x000001, gb_wdata=0x0E, gb_wen=gb_wstb=1 for exactly 1 cycle; cmd_ready=1 at T+2; wr_count=1.
- Read, RD=1: cmd read addr=0x000000 with rsp_ready=1, and a responder model returning 0x42 one cycle after rstb -> gb_rstb=1 only in T+1; rsp_valid=1 at T+3 with rsp_rdata=0x00000042; rd_count=1.
- Response backpressure, RD=3: hold rsp_ready=0 for 5 cycles after rsp_valid rises -> rsp_rdata is stable and cmd_ready=0 throughout, and gb_addr is unchanged. Then raise rsp_ready for 1 cycle -> rsp_valid=0 next cycle, and a queued command is accepted the cycle after that.
- Back-to-back: 4 writes (0x000004..0x000007, data 0x1..0x4), then 4 reads of the same addresses with cmd_valid held high -> wen pulses every 2 cycles; reads return 0x1..0x4 in order; wr_count=4, rd_count=4; rstb and wen never overlap.
- Reset mid-read, RD=3: assert rst_n=0 during WAIT -> all outputs 0 immediately, and no rsp_valid is ever produced. Release reset -> cmd_ready=1 on the first edge.
- Counter wrap, CW=4: 16 writes -> wr_count returns to 0 and the 17th write gives wr_count=1.
